// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and queue depth for the instruction fetch unit.
// Define IFETCH_PREFETCH_EN for a two-entry queue; default is one entry.
package ifetch_pkg;

`ifdef IFETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(FETCH_DEPTH);

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_CAP = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] pc;
    } entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM bus, redirect request and instruction handshake.
// master = fetch unit, slave = ROM/CPU side.
interface instr_fetch_if;
    logic [7:0] rom_addr;
    logic       rom_rd;
    logic [7:0] rom_data;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic [7:0] opcode1;
    logic [7:0] opcode2;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;

    modport master (
        output rom_addr, rom_rd,
        output opcode1, opcode2, instr_pc, instr_valid,
        input  rom_data, redirect, redirect_addr, instr_ready
    );

    modport slave (
        input  rom_addr, rom_rd,
        input  opcode1, opcode2, instr_pc, instr_valid,
        output rom_data, redirect, redirect_addr, instr_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: shift-style FIFO of fetched instructions, head at slot 0.
// Empty slots are held at zero so the head reads 00 when nothing is valid.
module ifetch_queue
    import ifetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output cnt_t   count,
    output entry_t head,
    output logic   valid
);

    entry_t mem [FETCH_DEPTH];
    cnt_t   count_n;
    cnt_t   wr_idx;

    // Occupancy after this cycle's push/pop; write slot accounts for the pop shift.
    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + cnt_t'(1);
        end else if (pop && !push) begin
            count_n = count - cnt_t'(1);
        end
        wr_idx = pop ? count - cnt_t'(1) : count;
    end

    // Storage update: clear on reset/flush, otherwise shift on pop and write on push.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                mem[i] <= '0;
            end
            count <= '0;
            valid <= 1'b0;
        end else begin
            if (pop) begin
                for (int i = 0; i < FETCH_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[FETCH_DEPTH-1] <= '0;
            end
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                if (push && wr_idx == cnt_t'(i)) begin
                    mem[i] <= din;
                end
            end
            count <= count_n;
            valid <= (count_n != '0);
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: two-byte instruction fetch from an 8-bit ROM into a small queue.
// Queue depth is 1, or 2 when IFETCH_PREFETCH_EN is defined.
module instr_fetch
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.master bus
);

    state_t     state;
    logic [7:0] fpc;
    logic [7:0] hi_q;
    logic [7:0] rd_addr;
    logic       rd_want;
    logic       push;
    logic       pop;
    logic       valid;
    logic       room_now;
    logic       room_next;
    cnt_t       count;
    cnt_t       count_after;
    entry_t     head;
    entry_t     push_entry;

    assign pop  = valid & bus.instr_ready;
    assign push = (state == S_CAP) & ~bus.redirect;

    assign push_entry = '{hi: hi_q, lo: bus.rom_data, pc: fpc};

    // Queue occupancy once this cycle's push and pop have both landed.
    always_comb begin
        count_after = count;
        if (push && !pop) begin
            count_after = count + cnt_t'(1);
        end else if (pop && !push) begin
            count_after = count - cnt_t'(1);
        end
    end

    assign room_now  = (count < DEPTH_C);
    assign room_next = (count_after < DEPTH_C);

    // ROM request for the current state; issued in the same cycle so data
    // is ready for capture on the next one.
    always_comb begin
        rd_want = 1'b0;
        rd_addr = fpc;
        unique case (state)
            S_HI: begin
                rd_want = room_now;
                rd_addr = fpc;
            end
            S_LO: begin
                rd_want = 1'b1;
                rd_addr = fpc + 8'd1;
            end
            S_CAP: begin
                rd_want = room_next;
                rd_addr = fpc + 8'd2;
            end
            default: begin
                rd_want = 1'b0;
                rd_addr = fpc;
            end
        endcase
    end

    // Reset and redirect cancel any read in their cycle.
    assign bus.rom_rd   = rd_want & ~reset & ~bus.redirect;
    assign bus.rom_addr = reset ? 8'h00 : rd_addr;

    // Fetch sequencer: hi byte, lo byte, push; redirect restarts at target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_HI;
            fpc   <= 8'h00;
            hi_q  <= 8'h00;
        end else if (bus.redirect) begin
            state <= S_HI;
            fpc   <= bus.redirect_addr;
        end else begin
            unique case (state)
                S_HI: begin
                    if (room_now) begin
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    hi_q  <= bus.rom_data;
                    state <= S_CAP;
                end
                S_CAP: begin
                    fpc   <= fpc + 8'd2;
                    state <= room_next ? S_LO : S_HI;
                end
                default: begin
                    state <= S_HI;
                end
            endcase
        end
    end

    ifetch_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .din   (push_entry),
        .count (count),
        .head  (head),
        .valid (valid)
    );

    assign bus.opcode1     = head.hi;
    assign bus.opcode2     = head.lo;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_valid = valid;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a scoreboard of consumed instructions.
// Works for either queue depth (IFETCH_PREFETCH_EN defined or not).
module tb_instr_fetch;
    import ifetch_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom [256];
    entry_t     exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // ROM model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rom_rd) begin
            bus.rom_data <= rom[bus.rom_addr];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic entry_t mk(logic [7:0] pc);
        logic [7:0] nx;
        nx = pc + 8'd1;
        return '{hi: rom[pc], lo: rom[nx], pc: pc};
    endfunction

    task automatic monitor();
        entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got %h/%h pc %h want none",
                             bus.opcode1, bus.opcode2, bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr",
                        {8'h00, bus.opcode1, bus.opcode2, bus.instr_pc},
                        {8'h00, e.hi, e.lo, e.pc});
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic consume(int n);
        int got = 0;
        int guard = 0;
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        while (got < n && guard < 100) begin
            @(negedge clk);
            guard++;
            if (bus.instr_valid) begin
                got++;
            end
        end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        if (got < n) begin
            n_checks++;
            $display("FAIL consume_timeout: got %0d want %0d", got, n);
        end
    endtask

    initial begin
        int t2;
        int rd_cnt;

        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'(i * 7 + 3);
        end
        rom[8'h00] = 8'h11;
        rom[8'h01] = 8'h25;
        rom[8'h02] = 8'h82;
        rom[8'h03] = 8'h34;
        rom[8'h40] = 8'hA1;
        rom[8'h41] = 8'hB2;
        rom[8'h42] = 8'hC3;
        rom[8'h43] = 8'hD4;
        rom[8'hFF] = 8'hEE;

        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = 8'h00;
        bus.instr_ready = 1'b0;

        fork
            monitor();
        join_none

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_outs",
            {bus.rom_rd, bus.instr_valid, bus.rom_addr,
             bus.opcode1, bus.opcode2},
            32'h0);
        chk("rst_pc", {24'h0, bus.instr_pc}, 32'h0);

        // First instructions, ready held high.
        do_reset();
        bus.instr_ready = 1'b1;
        exp_q.push_back('{hi: 8'h11, lo: 8'h25, pc: 8'h00});
        exp_q.push_back('{hi: 8'h82, lo: 8'h34, pc: 8'h02});
        t2 = (FETCH_DEPTH == 2) ? 5 : 7;
        for (int k = 0; k <= t2; k++) begin
            @(negedge clk);
            if (k == 0) chk("c0_fetch", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'h00});
            if (k == 1) chk("c1_fetch", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'h01});
            if (k == 2) chk("c2_valid", {31'h0, bus.instr_valid}, 32'h0);
            if (k == 3) chk("c3_head",
                            {bus.instr_valid, bus.opcode1, bus.opcode2, bus.instr_pc},
                            {1'b1, 8'h11, 8'h25, 8'h00});
            if (k == 4) chk("c4_valid", {bus.instr_valid, bus.opcode1, bus.opcode2},
                            {1'b0, 8'h00, 8'h00});
            if (k == t2) chk("second_head",
                             {bus.instr_valid, bus.opcode1, bus.opcode2, bus.instr_pc},
                             {1'b1, 8'h82, 8'h34, 8'h02});
        end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;

        // Back-pressure: exactly DEPTH instructions fetched.
        do_reset();
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rom_rd) rd_cnt++;
        end
        chk("stall_rd_cnt", rd_cnt, 2 * FETCH_DEPTH);
        chk("stall_rd", {31'h0, bus.rom_rd}, 32'h0);
        chk("stall_head",
            {bus.instr_valid, bus.opcode1, bus.opcode2, bus.instr_pc},
            {1'b1, 8'h11, 8'h25, 8'h00});
        for (int i = 0; i <= FETCH_DEPTH; i++) begin
            exp_q.push_back(mk(8'(2 * i)));
        end
        consume(FETCH_DEPTH + 1);

        // Redirect to 40 while in S_CAP.
        do_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h40;
        @(negedge clk);
        chk("redir_rd_gate", {31'h0, bus.rom_rd}, 32'h0);
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("redir_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("redir_fetch0", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'h40});
        @(negedge clk);
        chk("redir_fetch1", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'h41});
        exp_q.push_back('{hi: 8'hA1, lo: 8'hB2, pc: 8'h40});
        exp_q.push_back('{hi: 8'hC3, lo: 8'hD4, pc: 8'h42});
        consume(2);

        // Redirect to FF coincident with a handshake.
        repeat (12) @(posedge clk);
        #1;
        exp_q.push_back(mk(8'h44));
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'hFF;
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("wrap_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("wrap_fetch0", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'hFF});
        @(negedge clk);
        chk("wrap_fetch1", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'h00});
        @(negedge clk);
        chk("wrap_next_addr", {24'h0, bus.rom_addr}, 32'h01);
        exp_q.push_back('{hi: 8'hEE, lo: 8'h11, pc: 8'hFF});
        exp_q.push_back('{hi: 8'h25, lo: 8'h82, pc: 8'h01});
        consume(2);

        // Reset during S_LO.
        do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_outs",
            {bus.rom_rd, bus.instr_valid, bus.rom_addr,
             bus.opcode1, bus.opcode2},
            32'h0);
        chk("midrst_pc", {24'h0, bus.instr_pc}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_restart", {bus.rom_rd, bus.rom_addr}, {1'b1, 8'h00});
        exp_q.push_back('{hi: 8'h11, lo: 8'h25, pc: 8'h00});
        consume(1);

        repeat (2) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
